// File: rtl/key_pkg.sv
// key_pkg: shared key-line defaults and the active-low released level
package key_pkg;
  localparam int NKEYS_DEF = 4;
  localparam int DB_CYCLES_DEF = 500000;
  localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: synchronizer, debounce counter and edge strobes for one key
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic value,
  output logic press,
  output logic release_strobe,
  output logic accept
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  // accept is exported so the top can register change in the same cycle as the strobes
  always_comb accept = (s2 != value) && (cnt == LAST);
  // synchronize, count consecutive mismatches, and commit the new level after DB_CYCLES of them
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= KEY_RELEASED;
      s2 <= KEY_RELEASED;
      value <= KEY_RELEASED;
      cnt <= '0;
      press <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      press <= accept & ~s2;
      release_strobe <= accept & s2;
      cnt <= (s2 == value || accept) ? '0 : cnt + 1'b1;
      if (accept) value <= s2;
    end
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: per-key debounce channels with a registered any-edge flag
module key_debounce
  import key_pkg::*;
#(
  parameter int NKEYS = NKEYS_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] value,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_strobe,
  output logic change
);
  logic [NKEYS-1:0] accept;
  for (genvar i = 0; i < NKEYS; i++) begin : g_chan
    key_debounce_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_chan (
      .clk(clk),
      .reset(reset),
      .key_raw(keys_raw[i]),
      .value(value[i]),
      .press(press[i]),
      .release_strobe(release_strobe[i]),
      .accept(accept[i])
    );
  end
  // register change from the channels' acceptance so it lines up with the strobe flops
  always_ff @(posedge clk) begin
    if (reset) change <= 1'b0;
    else change <= |accept;
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench against a window-based debounce reference model
module tb_key_debounce;
  localparam int NK = 4;
  localparam int DB = 4;
  typedef struct packed {
    logic [NK-1:0] v;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic c;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] value, press, release_strobe;
  logic change;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int model_edges = 0;
  int dut_edges = 0;
  key_debounce #(.NKEYS(NK), .DB_CYCLES(DB)) dut (
    .clk(clk),
    .reset(reset),
    .keys_raw(keys_raw),
    .value(value),
    .press(press),
    .release_strobe(release_strobe),
    .change(change)
  );
  always #5 clk = ~clk;
  // reference: the pins reach the debouncer two edges late; a key flips once the last DB
  // synchronized samples all disagree with its current stable level
  initial begin
    logic [NK-1:0] pipe [2];
    logic [NK-1:0] win [DB];
    logic [NK-1:0] stable, sync, p, r;
    bit all_diff;
    forever begin
      @(posedge clk);
      p = '0;
      r = '0;
      if (reset) begin
        pipe[0] = '1;
        pipe[1] = '1;
        for (int j = 0; j < DB; j++) win[j] = '1;
        stable = '1;
      end else begin
        sync = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = keys_raw;
        for (int j = DB - 1; j > 0; j--) win[j] = win[j-1];
        win[0] = sync;
        for (int i = 0; i < NK; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++) if (win[j][i] == stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            if (sync[i]) r[i] = 1'b1;
            else p[i] = 1'b1;
            stable[i] = sync[i];
            model_edges++;
          end
        end
      end
      q.push_back('{v: stable, p: p, r: r, c: |(p | r)});
    end
  end
  // monitor: every cycle the DUT presents a result, compare it with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        dut_edges += $countones(press) + $countones(release_strobe);
        if ({value, press, release_strobe, change} !== e) begin
          errors++;
          $display("FAIL cycle t=%0t outputs value/press/release/change got %h/%h/%h/%b expected %h/%h/%h/%b",
                   $time, value, press, release_strobe, change, e.v, e.p, e.r, e.c);
        end
      end
    end
  end
  task automatic drive(input logic [NK-1:0] k, input logic rst, input int n);
    keys_raw = k;
    reset = rst;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int run [NK];
    logic [NK-1:0] lvl;
    drive(4'hF, 1'b1, 3);
    drive(4'hF, 1'b0, 20);
    drive(4'hE, 1'b0, 10);
    drive(4'hF, 1'b0, 10);
    for (int n = 0; n < 10; n++) begin
      drive(4'hE, 1'b0, 3);
      drive(4'hF, 1'b0, 1);
    end
    drive(4'hE, 1'b0, 12);
    drive(4'hF, 1'b0, 10);
    drive(4'h5, 1'b0, 10);
    drive(4'hF, 1'b0, 10);
    drive(4'hD, 1'b0, 3);
    drive(4'hD, 1'b1, 1);
    drive(4'hD, 1'b0, 10);
    drive(4'hF, 1'b0, 10);
    for (int i = 0; i < NK; i++) run[i] = 0;
    lvl = '1;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NK; i++) begin
        if (run[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          run[i] = $urandom_range(1, 9);
        end
        run[i]--;
      end
      drive(lvl, 1'($urandom_range(0, 199) == 0), 1);
    end
    drive(4'hF, 1'b0, 12);
    checks++;
    if (dut_edges != model_edges || model_edges == 0) begin
      errors++;
      $display("FAIL strobe_total got %0d expected %0d", dut_edges, model_edges);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
